rshift_mux_unit: RTL and testbench

- Registered 8-bit right-shift/rotate unit built only from 2:1 and 3:1 bit multiplexers, arranged as a 3-layer barrel shifter (shift by 1, 2, 4) plus a large-shift override stage.
- Sits in the ALU shift path and serves ROR, SRL and SRA.
- The 2:1 and 3:1 mux primitives are part of this block's contract; each must be implemented exactly as specified here.

---
 rtl/rshift_mux_unit_if.sv | 31 +++
 rtl/rshift_mux_unit.sv | 102 ++++++++++
 tb/tb_rshift_mux_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/rshift_mux_unit_if.sv
// Operand/result bundle for rshift_mux_unit. The ZERO flag exists only when
// RSH_ZERO_FLAG_EN is defined.
interface rshift_mux_unit_if #(
  parameter int WIDTH = 8
);
  logic             IN_VALID;
  logic [WIDTH-1:0] DATA1;
  logic [WIDTH-1:0] DATA2;
  logic [1:0]       SETPIN;
  logic [WIDTH-1:0] OUTPUT;
  logic             OUT_VALID;
`ifdef RSH_ZERO_FLAG_EN
  logic             ZERO;
`endif

  modport master (
    output IN_VALID, DATA1, DATA2, SETPIN,
    input  OUTPUT, OUT_VALID
`ifdef RSH_ZERO_FLAG_EN
    , input ZERO
`endif
  );

  modport slave (
    input  IN_VALID, DATA1, DATA2, SETPIN,
    output OUTPUT, OUT_VALID
`ifdef RSH_ZERO_FLAG_EN
    , output ZERO
`endif
  );
endinterface

// File: rtl/rshift_mux_unit.sv
// Registered 8-bit ROR/SRL/SRA barrel shifter built from 2:1 and 3:1 bit muxes.
// Optional RSH_ZERO_FLAG_EN adds a registered result-is-zero flag.
module rshift_mux_unit #(
  parameter int WIDTH = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  rshift_mux_unit_if.slave    bus
);

  function automatic logic mux2(input logic sel, input logic in0, input logic in1);
    return sel ? in1 : in0;
  endfunction

  // Reserved select 01 yields 0, which is what makes mode 01 act as SRL.
  function automatic logic mux3(input logic [1:0] sel, input logic in0,
                                input logic in1, input logic in2);
    logic res;
    case (sel)
      2'b00:   res = in0;
      2'b10:   res = in1;
      2'b11:   res = in2;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Stage p0: combinational shift network on the live inputs
  logic [WIDTH-1:0] data_p0;
  logic [WIDTH-1:0] amt_p0;
  logic [1:0]       mode_p0;
  logic [WIDTH-1:0] s0_p0;
  logic [WIDTH-1:0] s1_p0;
  logic [WIDTH-1:0] s2_p0;
  logic [WIDTH-1:0] result_p0;
  logic             ge8_p0;

  assign data_p0 = bus.DATA1;
  assign amt_p0  = bus.DATA2;
  assign mode_p0 = bus.SETPIN;
  assign ge8_p0  = |amt_p0[7:3];

  for (genvar i = 0; i < 7; i++) begin : g_l1
    assign s0_p0[i] = mux2(amt_p0[0], data_p0[i], data_p0[i+1]);
  end
  assign s0_p0[7] = mux2(amt_p0[0], data_p0[7],
                         mux3(mode_p0, data_p0[0], 1'b0, data_p0[7]));

  for (genvar i = 0; i < 6; i++) begin : g_l2
    assign s1_p0[i] = mux2(amt_p0[1], s0_p0[i], s0_p0[i+2]);
  end
  for (genvar i = 6; i < 8; i++) begin : g_l2_fill
    assign s1_p0[i] = mux2(amt_p0[1], s0_p0[i],
                           mux3(mode_p0, s0_p0[i-6], 1'b0, s0_p0[7]));
  end

  for (genvar i = 0; i < 4; i++) begin : g_l3
    assign s2_p0[i] = mux2(amt_p0[2], s1_p0[i], s1_p0[i+4]);
  end
  for (genvar i = 4; i < 8; i++) begin : g_l3_fill
    assign s2_p0[i] = mux2(amt_p0[2], s1_p0[i],
                           mux3(mode_p0, s1_p0[i-4], 1'b0, s1_p0[7]));
  end

  // ROR passes s2 through the override, so rotation ignores DATA2[7:3].
  for (genvar i = 0; i < 8; i++) begin : g_big
    assign result_p0[i] = mux2(ge8_p0, s2_p0[i],
                               mux3(mode_p0, s2_p0[i], 1'b0, data_p0[7]));
  end

  // Stage p1: output registers
  logic [WIDTH-1:0] result_p1;
  logic             vld_p1;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      result_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= bus.IN_VALID;
      if (bus.IN_VALID) result_p1 <= result_p0;
    end
  end

  assign bus.OUTPUT    = result_p1;
  assign bus.OUT_VALID = vld_p1;

`ifdef RSH_ZERO_FLAG_EN
  logic zero_p1;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      zero_p1 <= 1'b1;
    end else if (bus.IN_VALID) begin
      zero_p1 <= (result_p0 == '0);
    end
  end

  assign bus.ZERO = zero_p1;
`endif

endmodule

// File: tb/tb_rshift_mux_unit.sv
// Bench for rshift_mux_unit: arithmetic reference model checked every cycle
// plus directed vectors with literal expected results.
module tb_rshift_mux_unit;
  logic CLK;
  logic RESET;
  int   total;
  int   bad;
  logic check_en;

  rshift_mux_unit_if #(.WIDTH(8)) bus ();

  rshift_mux_unit #(.WIDTH(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [7:0] a,
                                           input logic [1:0] m);
    logic [15:0] dd;
    logic [7:0]  r;
    if (m == 2'b00) begin
      dd = {d, d} >> (a % 8);
      r  = dd[7:0];
    end else if (m == 2'b11) begin
      r = (a >= 8) ? {8{d[7]}} : 8'($signed(d) >>> a);
    end else begin
      r = (a >= 8) ? 8'h00 : (d >> a);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Reference model: expected registered outputs derived from the inputs.
  logic [7:0] m_out;
  logic       m_vld;
  logic       m_zero;
  always @(posedge CLK) begin
    if (!RESET) begin
      m_out  <= 8'h00;
      m_vld  <= 1'b0;
      m_zero <= 1'b1;
    end else begin
      m_vld <= bus.IN_VALID;
      if (bus.IN_VALID) begin
        m_out  <= ref_shift(bus.DATA1, bus.DATA2, bus.SETPIN);
        m_zero <= (ref_shift(bus.DATA1, bus.DATA2, bus.SETPIN) == 8'h00);
      end
    end
  end

  always @(negedge CLK) begin
    if (check_en) begin
      chk("model_out", bus.OUTPUT, m_out);
      chk("model_vld", {7'b0, bus.OUT_VALID}, {7'b0, m_vld});
`ifdef RSH_ZERO_FLAG_EN
      chk("model_zero", {7'b0, bus.ZERO}, {7'b0, m_zero});
`endif
    end
  end

  task automatic do_op(input string name, input logic [7:0] d, input logic [7:0] a,
                       input logic [1:0] m, input logic [7:0] want);
    @(negedge CLK);
    bus.IN_VALID = 1'b1;
    bus.DATA1    = d;
    bus.DATA2    = a;
    bus.SETPIN   = m;
    @(negedge CLK);
    bus.IN_VALID = 1'b0;
    chk({name, "_ref"}, ref_shift(d, a, m), want);
    chk(name, bus.OUTPUT, want);
    chk({name, "_vld"}, {7'b0, bus.OUT_VALID}, 8'h01);
`ifdef RSH_ZERO_FLAG_EN
    chk({name, "_zero"}, {7'b0, bus.ZERO}, {7'b0, (want == 8'h00)});
`endif
  endtask

  initial begin
    int vcount;
    logic [7:0] held;
    total    = 0;
    bad      = 0;
    check_en = 1'b0;
    RESET    = 1'b0;
    bus.IN_VALID = 1'b1;
    bus.DATA1    = 8'hFF;
    bus.DATA2    = 8'h00;
    bus.SETPIN   = 2'b00;

    // Reset held two cycles with a pending operation that must be dropped.
    @(posedge CLK);
    @(negedge CLK);
    check_en = 1'b1;
    @(negedge CLK);
    chk("rst_out", bus.OUTPUT, 8'h00);
    chk("rst_vld", {7'b0, bus.OUT_VALID}, 8'h00);
`ifdef RSH_ZERO_FLAG_EN
    chk("rst_zero", {7'b0, bus.ZERO}, 8'h01);
`endif
    bus.IN_VALID = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    chk("post_rst_out", bus.OUTPUT, 8'h00);

    do_op("ror1",   8'b10011001, 8'd1,  2'b00, 8'b11001100);
    do_op("ror3",   8'b11000011, 8'd3,  2'b00, 8'b01111000);
    do_op("ror2",   8'b11110001, 8'd2,  2'b00, 8'b01111100);
    do_op("ror0",   8'b11110001, 8'd0,  2'b00, 8'b11110001);
    do_op("ror11",  8'b11000011, 8'd11, 2'b00, 8'b01111000);
    do_op("sra1",   8'b10011001, 8'd1,  2'b11, 8'b11001100);
    do_op("sra3",   8'b11100000, 8'd3,  2'b11, 8'b11111100);
    do_op("sra7",   8'b10000000, 8'd7,  2'b11, 8'b11111111);
    do_op("sra48",  8'b10000000, 8'h48, 2'b11, 8'b11111111);
    do_op("sra_pos",8'b01110000, 8'd9,  2'b11, 8'b00000000);
    do_op("srl2",   8'b11110001, 8'd2,  2'b10, 8'b00111100);
    do_op("rsv23",  8'b11110001, 8'h23, 2'b01, 8'b00000000);
    do_op("rsv1",   8'b11110001, 8'd1,  2'b01, 8'b01111000);
    do_op("srl8",   8'hFF,       8'd8,  2'b10, 8'b00000000);
    do_op("srl80",  8'hFF,       8'h80, 2'b10, 8'b00000000);

    // Hold: one op, then three idle cycles with DATA1 moving.
    do_op("hold_op", 8'b10100101, 8'd4, 2'b00, 8'b01011010);
    held   = bus.OUTPUT;
    vcount = 0;
    for (int i = 0; i < 3; i++) begin
      bus.DATA1 = 8'(i * 37 + 1);
      bus.SETPIN = 2'(i);
      @(negedge CLK);
      if (bus.OUT_VALID) vcount++;
      chk("hold_out", bus.OUTPUT, held);
    end
    chk("hold_vld_cnt", 8'(vcount), 8'd0);

    // Back-to-back ops: model tracks every cycle.
    for (int m = 0; m < 4; m++) begin
      for (int a = 0; a < 10; a++) begin
        @(negedge CLK);
        bus.IN_VALID = 1'b1;
        bus.DATA1    = 8'(8'h96 ^ (a * 17));
        bus.DATA2    = 8'(a);
        bus.SETPIN   = 2'(m);
      end
    end
    @(negedge CLK);
    bus.IN_VALID = 1'b0;

    // Reset asserted mid-stream drops the concurrent operation.
    @(negedge CLK);
    RESET = 1'b0;
    bus.IN_VALID = 1'b1;
    bus.DATA1 = 8'hF0;
    bus.DATA2 = 8'd1;
    bus.SETPIN = 2'b10;
    @(negedge CLK);
    chk("rst2_out", bus.OUTPUT, 8'h00);
    chk("rst2_vld", {7'b0, bus.OUT_VALID}, 8'h00);
    RESET = 1'b1;
    bus.IN_VALID = 1'b0;
    @(negedge CLK);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
